// File: rtl/axi_blk_mem_gen_if.sv
// axi_blk_mem_gen_if: AXI4 bus bundle between a master and the block-memory slave.
interface axi_blk_mem_gen_if #(
    parameter int G_DATAWIDTH = 32
);
    logic                       awid;
    logic [31:0]                awaddr;
    logic [7:0]                 awlen;
    logic [2:0]                 awsize;
    logic [1:0]                 awburst;
    logic                       awvalid;
    logic                       awready;
    logic [G_DATAWIDTH-1:0]     wdata;
    logic [G_DATAWIDTH/8-1:0]   wstrb;
    logic                       wlast;
    logic                       wvalid;
    logic                       wready;
    logic                       bid;
    logic [1:0]                 bresp;
    logic                       bvalid;
    logic                       bready;
    logic                       arid;
    logic [31:0]                araddr;
    logic [7:0]                 arlen;
    logic [2:0]                 arsize;
    logic [1:0]                 arburst;
    logic                       arvalid;
    logic                       arready;
    logic                       rid;
    logic [G_DATAWIDTH-1:0]     rdata;
    logic [1:0]                 rresp;
    logic                       rlast;
    logic                       rvalid;
    logic                       rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        input  rready,
        output awready, wready, bid, bresp, bvalid,
        output arready, rid, rdata, rresp, rlast, rvalid
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        output rready,
        input  awready, wready, bid, bresp, bvalid,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_blk_mem_gen.sv
// axi_blk_mem_gen: AXI4 burst slave over a block RAM with independent read/write FSMs.
module axi_blk_mem_gen #(
    parameter int    G_DATAWIDTH = 32,
    parameter int    G_MEMDEPTH  = 1024,
    parameter string G_INIT_FILE = ""
) (
    input  logic             s_aclk,
    input  logic             s_aresetn,
    axi_blk_mem_gen_if.slave s_axi
);
    localparam int          BYTES    = G_DATAWIDTH / 8;
    localparam int          BSZ      = $clog2(BYTES);
    localparam int          AW       = $clog2(G_MEMDEPTH);
    localparam logic [31:0] DEPTH    = 32'(G_MEMDEPTH);
    localparam logic [2:0]  MAX_SIZE = 3'(BSZ);
    localparam logic [1:0]  FIXED    = 2'b00;
    localparam logic [1:0]  WRAP     = 2'b10;
    localparam logic [1:0]  OKAY     = 2'b00;
    localparam logic [1:0]  SLVERR   = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        return AW'((a >> BSZ) % DEPTH);
    endfunction

    function automatic logic [2:0] clamp_size(input logic [2:0] s);
        return (s > MAX_SIZE) ? MAX_SIZE : s;
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] step;
        logic [31:0] mask;
        logic        wrap_ok;
        step    = 32'd1 << size;
        mask    = ((32'(len) + 32'd1) << size) - 32'd1;
        wrap_ok = len inside {8'd1, 8'd3, 8'd7, 8'd15};
        return (burst == FIXED) ? a :
               (burst == WRAP && wrap_ok) ? ((a & ~mask) | ((a + step) & mask)) : a + step;
    endfunction

    logic [G_DATAWIDTH-1:0] mem [G_MEMDEPTH];

    initial begin
        for (int i = 0; i < G_MEMDEPTH; i++) mem[i] = '0;
    end

    logic       rst_done_q;
    w_state_t   w_state_q, w_state_d;
    logic       awid_q, awid_d;
    logic [31:0] waddr_q, waddr_d;
    logic [7:0] awlen_q, awlen_d;
    logic [2:0] awsize_q, awsize_d;
    logic [1:0] awburst_q, awburst_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic       werr_q, werr_d;
    logic       mem_we;
    logic       w_oob;

    r_state_t   r_state_q, r_state_d;
    logic       arid_q, arid_d;
    logic [31:0] raddr_q, raddr_d;
    logic [7:0] arlen_q, arlen_d;
    logic [2:0] arsize_q, arsize_d;
    logic [1:0] arburst_q, arburst_d;
    logic [7:0] rcnt_q, rcnt_d;
    logic [G_DATAWIDTH-1:0] rdata_q;
    logic [1:0] rresp_q;
    logic       rd_en;
    logic [31:0] rd_addr;
    logic       r_oob;
    logic       r_last;
    logic       unused_wlast;

    assign unused_wlast = s_axi.wlast;

`ifdef BLK_MEM_ERR_RESP_EN
    assign w_oob = (waddr_q >> BSZ) >= DEPTH;
    assign r_oob = (rd_addr >> BSZ) >= DEPTH;
`else
    assign w_oob = 1'b0;
    assign r_oob = 1'b0;
`endif

    always_comb begin
        w_state_d = w_state_q;
        awid_d    = awid_q;
        waddr_d   = waddr_q;
        awlen_d   = awlen_q;
        awsize_d  = awsize_q;
        awburst_d = awburst_q;
        wcnt_d    = wcnt_q;
        werr_d    = werr_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: if (s_axi.awvalid && rst_done_q) begin
                awid_d    = s_axi.awid;
                waddr_d   = s_axi.awaddr;
                awlen_d   = s_axi.awlen;
                awsize_d  = clamp_size(s_axi.awsize);
                awburst_d = s_axi.awburst;
                wcnt_d    = 8'd0;
                werr_d    = 1'b0;
                w_state_d = W_DATA;
            end
            W_DATA: if (s_axi.wvalid) begin
                mem_we    = !w_oob;
                werr_d    = werr_q | w_oob;
                waddr_d   = next_addr(waddr_q, awlen_q, awsize_q, awburst_q);
                wcnt_d    = wcnt_q + 8'd1;
                w_state_d = (wcnt_q == awlen_q) ? W_RESP : W_DATA;
            end
            W_RESP: w_state_d = s_axi.bready ? W_IDLE : W_RESP;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        arid_d    = arid_q;
        raddr_d   = raddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        arburst_d = arburst_q;
        rcnt_d    = rcnt_q;
        rd_en     = 1'b0;
        rd_addr   = raddr_q;
        case (r_state_q)
            R_IDLE: if (s_axi.arvalid && rst_done_q) begin
                rd_en     = 1'b1;
                rd_addr   = s_axi.araddr;
                raddr_d   = s_axi.araddr;
                arid_d    = s_axi.arid;
                arlen_d   = s_axi.arlen;
                arsize_d  = clamp_size(s_axi.arsize);
                arburst_d = s_axi.arburst;
                rcnt_d    = 8'd0;
                r_state_d = R_DATA;
            end
            R_DATA: if (s_axi.rready) begin
                if (r_last) begin
                    r_state_d = R_IDLE;
                end else begin
                    rd_en   = 1'b1;
                    rd_addr = next_addr(raddr_q, arlen_q, arsize_q, arburst_q);
                    raddr_d = rd_addr;
                    rcnt_d  = rcnt_q + 8'd1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always @(posedge s_aclk) begin
        if (mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (s_axi.wstrb[b]) mem[word_idx(waddr_q)][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            rst_done_q <= 1'b0;
            w_state_q  <= W_IDLE;
            awid_q     <= 1'b0;
            waddr_q    <= '0;
            awlen_q    <= '0;
            awsize_q   <= '0;
            awburst_q  <= '0;
            wcnt_q     <= '0;
            werr_q     <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
            w_state_q  <= w_state_d;
            awid_q     <= awid_d;
            waddr_q    <= waddr_d;
            awlen_q    <= awlen_d;
            awsize_q   <= awsize_d;
            awburst_q  <= awburst_d;
            wcnt_q     <= wcnt_d;
            werr_q     <= werr_d;
        end
    end

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            r_state_q <= R_IDLE;
            arid_q    <= 1'b0;
            raddr_q   <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
            rcnt_q    <= '0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
        end else begin
            r_state_q <= r_state_d;
            arid_q    <= arid_d;
            raddr_q   <= raddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            arburst_q <= arburst_d;
            rcnt_q    <= rcnt_d;
            if (rd_en) begin
                rdata_q <= r_oob ? '0 : mem[word_idx(rd_addr)];
                rresp_q <= r_oob ? SLVERR : OKAY;
            end
        end
    end

    assign r_last        = (r_state_q == R_DATA) && (rcnt_q == arlen_q);
    assign s_axi.awready = rst_done_q && (w_state_q == W_IDLE);
    assign s_axi.wready  = (w_state_q == W_DATA);
    assign s_axi.bvalid  = (w_state_q == W_RESP);
    assign s_axi.bid     = awid_q;
    assign s_axi.bresp   = werr_q ? SLVERR : OKAY;
    assign s_axi.arready = rst_done_q && (r_state_q == R_IDLE);
    assign s_axi.rvalid  = (r_state_q == R_DATA);
    assign s_axi.rid     = arid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rlast   = r_last;
endmodule

// File: tb/tb_axi_blk_mem_gen.sv
// tb_axi_blk_mem_gen: directed AXI bursts with a read-beat scoreboard.
module tb_axi_blk_mem_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    axi_blk_mem_gen_if #(.G_DATAWIDTH(32)) bus ();

    axi_blk_mem_gen #(.G_DATAWIDTH(32), .G_MEMDEPTH(1024), .G_INIT_FILE("")) dut (
        .s_aclk(clk),
        .s_aresetn(rst_n),
        .s_axi(bus)
    );

    typedef struct {
        logic [31:0] d;
        logic        last;
        logic [1:0]  resp;
        logic        id;
    } rexp_t;

    rexp_t rexp_q[$];
    rexp_t cur;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic last, input logic [1:0] resp, input logic id);
        rexp_q.push_back('{d, last, resp, id});
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.rvalid) begin
            if (bus.rready) begin
                tests++;
                assert (rexp_q.size() > 0) else begin
                    fails++;
                    $error("FAIL extra_rbeat: observed beat %h expected none", bus.rdata);
                end
                if (rexp_q.size() > 0) begin
                    cur = rexp_q.pop_front();
                    chk("rdata", bus.rdata, cur.d);
                    chk("rlast", bus.rlast, cur.last);
                    chk("rresp", bus.rresp, cur.resp);
                    chk("rid", bus.rid, cur.id);
                end
            end else if (rexp_q.size() > 0) begin
                chk("stall_rdata", bus.rdata, rexp_q[0].d);
                chk("stall_rlast", bus.rlast, rexp_q[0].last);
            end
        end
    end

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic id, input logic [31:0] base, input logic [3:0] strb,
                            input logic [1:0] exp_resp);
        int n;
        @(posedge clk); #1;
        bus.awvalid = 1'b1; bus.awaddr = addr; bus.awlen = len;
        bus.awsize = 3'd2; bus.awburst = burst; bus.awid = id;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.awready && n < 20);
        chk("aw_handshake", bus.awready, 1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            bus.wvalid = 1'b1; bus.wdata = base + 32'(i); bus.wstrb = strb; bus.wlast = (i == int'(len));
            @(negedge clk);
            chk("wready", bus.wready, 1);
            if (i == 0) chk("awready_busy", bus.awready, 0);
            @(posedge clk); #1;
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.bready = 1'b1;
        @(negedge clk);
        chk("bvalid", bus.bvalid, 1);
        chk("bresp", bus.bresp, exp_resp);
        chk("bid", bus.bid, id);
        @(posedge clk); #1;
        bus.bready = 1'b0;
        @(negedge clk);
        chk("awready_after_b", bus.awready, 1);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic id, input bit toggle, output int cycles);
        int n;
        @(posedge clk); #1;
        bus.arvalid = 1'b1; bus.araddr = addr; bus.arlen = len;
        bus.arsize = 3'd2; bus.arburst = burst; bus.arid = id;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.arready && n < 20);
        chk("ar_handshake", bus.arready, 1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0; bus.rready = 1'b1;
        @(negedge clk);
        chk("rvalid_first", bus.rvalid, 1);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            if (rexp_q.size() == 0) break;
            #1 bus.rready = toggle ? ~bus.rready : 1'b1;
        end while (n < 100);
        cycles = n;
        chk("read_done", rexp_q.size(), 0);
        rexp_q.delete();
        #1 bus.rready = 1'b0;
        @(negedge clk);
        chk("arready_after_r", bus.arready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bus.awvalid = 0; bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
        bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
        bus.arvalid = 0; bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
        bus.rready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", bus.awready, 0);
        chk("rst_wready", bus.wready, 0);
        chk("rst_bvalid", bus.bvalid, 0);
        chk("rst_arready", bus.arready, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_rlast", bus.rlast, 0);
        chk("rst_bid", bus.bid, 0);
        chk("rst_rid", bus.rid, 0);
        chk("rst_bresp", bus.bresp, 0);
        chk("rst_rresp", bus.rresp, 0);
        chk("rst_rdata", bus.rdata, 0);
        #1 rst_n = 1'b1;
        #1 chk("awready_before_edge", bus.awready, 0);
        @(negedge clk);
        chk("awready_after_rel", bus.awready, 1);
        chk("arready_after_rel", bus.arready, 1);

        do_write(32'h10, 8'd0, 2'b01, 1'b1, 32'hDEADBEEF, 4'hF, 2'b00);
        push(32'hDEADBEEF, 1'b1, 2'b00, 1'b1);
        do_read(32'h10, 8'd0, 2'b01, 1'b1, 1'b0, cyc);

        do_write(32'h20, 8'd0, 2'b01, 1'b0, 32'h11223344, 4'hF, 2'b00);
        do_write(32'h20, 8'd0, 2'b01, 1'b0, 32'hAABBCCDD, 4'h5, 2'b00);
        push(32'h11BB33DD, 1'b1, 2'b00, 1'b0);
        do_read(32'h20, 8'd0, 2'b01, 1'b0, 1'b0, cyc);

        do_write(32'h100, 8'd7, 2'b01, 1'b0, 32'd0, 4'hF, 2'b00);
        for (int i = 0; i < 8; i++) push(32'(i), i == 7, 2'b00, 1'b0);
        do_read(32'h100, 8'd7, 2'b01, 1'b0, 1'b0, cyc);
        chk("incr_cycles", cyc, 8);

        push(32'd2, 1'b0, 2'b00, 1'b1);
        push(32'd3, 1'b0, 2'b00, 1'b1);
        push(32'd0, 1'b0, 2'b00, 1'b1);
        push(32'd1, 1'b1, 2'b00, 1'b1);
        do_read(32'h108, 8'd3, 2'b10, 1'b1, 1'b0, cyc);

        for (int i = 0; i < 8; i++) push(32'(i), i == 7, 2'b00, 1'b0);
        do_read(32'h100, 8'd7, 2'b01, 1'b0, 1'b1, cyc);

        do_write(32'h40, 8'd3, 2'b00, 1'b1, 32'hA0, 4'hF, 2'b00);
        push(32'hA3, 1'b1, 2'b00, 1'b0);
        do_read(32'h40, 8'd0, 2'b01, 1'b0, 1'b0, cyc);

        push(32'd0, 1'b1, 2'b00, 1'b0);
        do_read(32'h300, 8'd0, 2'b01, 1'b0, 1'b0, cyc);

`ifdef BLK_MEM_ERR_RESP_EN
        do_write(32'h1050, 8'd0, 2'b01, 1'b0, 32'h77, 4'hF, 2'b10);
        push(32'd0, 1'b1, 2'b00, 1'b0);
        do_read(32'h50, 8'd0, 2'b01, 1'b0, 1'b0, cyc);
        push(32'd0, 1'b1, 2'b10, 1'b0);
        do_read(32'h1000, 8'd0, 2'b01, 1'b0, 1'b0, cyc);
`else
        do_write(32'h1050, 8'd0, 2'b01, 1'b0, 32'h77, 4'hF, 2'b00);
        push(32'h77, 1'b1, 2'b00, 1'b0);
        do_read(32'h50, 8'd0, 2'b01, 1'b0, 1'b0, cyc);
        push(32'd0, 1'b1, 2'b00, 1'b0);
        do_read(32'h1000, 8'd0, 2'b01, 1'b0, 1'b0, cyc);
`endif

        @(posedge clk); #1;
        bus.awvalid = 1'b1; bus.awaddr = 32'h10; bus.awlen = 8'd3; bus.awburst = 2'b01; bus.awid = 1'b1;
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        @(negedge clk);
        chk("midburst_wready", bus.wready, 1);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_wready", bus.wready, 0);
        chk("midrst_awready", bus.awready, 0);
        chk("midrst_bvalid", bus.bvalid, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_awready_back", bus.awready, 1);
        push(32'hDEADBEEF, 1'b1, 2'b00, 1'b0);
        do_read(32'h10, 8'd0, 2'b01, 1'b0, 1'b0, cyc);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
